io_hex_output: RTL
==================

IO_HEX_OUTPUT -- requirements
Module: io_hex_output

Interface
REQ-001 SHALL have parameter BLANK_LEADING, default 1, meaning a tens digit of 0 is shown blank when 1.
REQ-002 SHALL have parameter CONV_BITS, default 7, meaning the binary width converted to two BCD digits.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  CPU store strobe to an output port, one cycle per store.
REQ-006 SHALL have port addr  input  2  port select: 0 = out_port0, 1 = out_port1, 2 = out_port2, 3 = ignored.
REQ-007 SHALL have port wr_data  input  32  store data.
REQ-008 SHALL have ports out_port0, out_port1, out_port2  output  32 each  registered readback of the last stored values.
REQ-009 SHALL have ports hex0..hex5  output  7 each  active-low segments, bit6..bit0 = g..a.
REQ-010 SHALL have port busy  output  1  high while a conversion is in progress or any port is pending.

Function
REQ-011 A store with wr_en=1 and addr 0..2 SHALL update out_portN on that edge and set pending[N].
REQ-012 A store with addr 3 SHALL change no state.
REQ-013 Display mapping SHALL be {hex1,hex0} = out_port0, {hex3,hex2} = out_port1, {hex5,hex4} = out_port2, with the tens digit on the odd display.
REQ-014 The FSM SHALL have the states IDLE, SHIFT and STORE.
REQ-015 In IDLE with any pending bit set, the FSM SHALL select the lowest pending index, capture that port's value, clear its pending bit, load the shift counter with CONV_BITS and enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL perform one double-dabble step: add 3 to each BCD nibble that is at least 5, then shift left one bit; after CONV_BITS steps the FSM SHALL enter STORE.
REQ-017 In STORE, the FSM SHALL write the selected display pair and return to IDLE.
REQ-018 Latency SHALL be exactly CONV_BITS+2 clocks (9 at default) from the write edge to the updated hex outputs, when the FSM is idle at the time of the write.
REQ-019 A captured value greater than 99 SHALL display dash, dash (7'b0111111 on both digits) and SHALL NOT be converted arithmetically; the cycle count SHALL be unchanged.
REQ-020 Digit encodings SHALL be: 0..9 standard active-low (0 = 7'b1000000, 8 = 7'b0000000); blank = 7'b1111111.
REQ-021 With BLANK_LEADING=1 and a value of 0..9, the tens digit SHALL be blank; the value 0 SHALL show blank, 0.
REQ-022 A write to port N on the same edge on which IDLE captures port N SHALL leave pending[N] set; the new value SHALL be converted next.
REQ-023 A write to the port currently in SHIFT or STORE SHALL set pending; the stale result SHALL still be stored and a reconversion SHALL follow.
REQ-024 Repeated writes to one port before it is serviced SHALL coalesce, so that only the last value is displayed.
REQ-025 Ports SHALL be serviced in priority order 0 > 1 > 2; there is no fairness guarantee beyond this order.

Reset
REQ-026 Reset SHALL set out_port0..2 = 0, pending = 0, FSM = IDLE, shift counter = 0 and busy = 0.
REQ-027 Reset SHALL set hex0, hex2 and hex4 to 7'b1000000 (digit 0), and hex1, hex3 and hex5 to blank when BLANK_LEADING=1, else to digit 0.
REQ-028 Reset SHALL take priority over wr_en on the same edge.
REQ-029 Reset asserted mid-conversion SHALL abort the conversion with no display update.

Structure
REQ-030 Package io_hex_pkg SHALL hold the FSM state enum, the segment constants (SEG_BLANK, SEG_DASH, digit table) and the port address constants.
REQ-031 Sub-module bcd_to_seg7 SHALL be purely combinational (4-bit BCD plus blank flag in, 7-bit segments out) and SHALL be instantiated twice for the tens and units digits.
REQ-032 A single double-dabble converter SHALL be time-shared across all three ports.

Verification
REQ-033 Reset, then write 11 to port 0 -> hex1 = 7'b1111001 and hex0 = 7'b1111001 exactly 9 cycles later; busy high for those 9 cycles.
REQ-034 Same-edge reset and write -> all outputs hold their reset values.
REQ-035 Write 5 to port 1 -> hex3 = blank and hex2 = 7'b0010010; write 0 to port 1 -> hex3 = blank and hex2 = 7'b1000000.
REQ-036 Write 150 to port 2 -> hex5 = hex4 = 7'b0111111 after 9 cycles; out_port2 reads 150.
REQ-037 Write 37 to port 2, then 42 to port 0 one cycle later -> port 2 is displayed at cycle 9 and port 0 at cycle 18.
REQ-038 Write 99 to port 0, then write 7 to port 0 during SHIFT -> 9, 9 is displayed briefly, then blank, 7 is displayed 9 cycles after the first STORE.

Source files
------------

// File: rtl/io_hex_pkg.sv
// Shared FSM states, port addresses and 7-segment codes for the hex output block.
package io_hex_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STORE
  } state_t;

  localparam logic [1:0] ADDR_PORT0 = 2'd0;
  localparam logic [1:0] ADDR_PORT1 = 2'd1;
  localparam logic [1:0] ADDR_PORT2 = 2'd2;
  localparam logic [1:0] ADDR_NONE  = 2'd3;

  // Active-low segments, bit6..bit0 = g..a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_ZERO;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module bcd_to_seg7
  import io_hex_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : digit_seg(bcd);
  end

endmodule

// File: rtl/io_hex_output.sv
// Three CPU output ports shown as two-digit decimal on six seven-segment displays,
// converted by one shared double-dabble engine.
module io_hex_output
  import io_hex_pkg::*;
#(
  parameter int unsigned BLANK_LEADING = 1,
  parameter int unsigned CONV_BITS     = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(CONV_BITS + 1);
  localparam logic [6:0] SEG_TENS_RST = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_ZERO;

  state_t               state, state_next;
  logic [2:0]           pending;
  logic [2:0]           wr_set;
  logic [2:0]           pick_mask;
  logic [1:0]           pick;
  logic [31:0]          pick_val;
  logic                 take;
  logic [1:0]           sel;
  logic [CNT_W-1:0]     count;
  logic                 over;
  logic [7:0]           bcd;
  logic [CONV_BITS-1:0] bin;
  logic [3:0]           lo_adj;
  logic [2:0]           hi_adj;
  logic                 tens_blank;
  logic [6:0]           tens_raw, units_raw, tens_seg, units_seg;

  always_comb begin
    wr_set = '0;
    if (wr_en) begin
      case (addr)
        ADDR_PORT0: wr_set = 3'b001;
        ADDR_PORT1: wr_set = 3'b010;
        ADDR_PORT2: wr_set = 3'b100;
        ADDR_NONE:  wr_set = '0;
      endcase
    end
  end

  always_comb begin
    pick      = ADDR_PORT0;
    pick_val  = out_port0;
    pick_mask = 3'b001;
    if (pending[0]) begin
      pick      = ADDR_PORT0;
      pick_val  = out_port0;
      pick_mask = 3'b001;
    end else if (pending[1]) begin
      pick      = ADDR_PORT1;
      pick_val  = out_port1;
      pick_mask = 3'b010;
    end else if (pending[2]) begin
      pick      = ADDR_PORT2;
      pick_val  = out_port2;
      pick_mask = 3'b100;
    end
    take = (state == IDLE) && (pending != '0);
  end

  // Double-dabble step: correct nibbles >= 5, then shift the next binary bit in.
  always_comb begin
    lo_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    hi_adj = 3'((bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4]);
  end

  always_comb begin
    tens_blank = (BLANK_LEADING != 0) && (bcd[7:4] == 4'd0);
    tens_seg   = over ? SEG_DASH : tens_raw;
    units_seg  = over ? SEG_DASH : units_raw;
  end

  bcd_to_seg7 u_tens (
    .bcd   (bcd[7:4]),
    .blank (tens_blank),
    .seg   (tens_raw)
  );

  bcd_to_seg7 u_units (
    .bcd   (bcd[3:0]),
    .blank (1'b0),
    .seg   (units_raw)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = SHIFT;
      SHIFT:   if (count == CNT_W'(1)) state_next = STORE;
      STORE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
      pending   <= '0;
      sel       <= ADDR_PORT0;
      count     <= '0;
      over      <= 1'b0;
      bcd       <= '0;
      bin       <= '0;
      hex0      <= SEG_ZERO;
      hex1      <= SEG_TENS_RST;
      hex2      <= SEG_ZERO;
      hex3      <= SEG_TENS_RST;
      hex4      <= SEG_ZERO;
      hex5      <= SEG_TENS_RST;
    end else begin
      if (wr_set[0]) out_port0 <= wr_data;
      if (wr_set[1]) out_port1 <= wr_data;
      if (wr_set[2]) out_port2 <= wr_data;
      // A write landing on the capture edge wins, so the newer value is converted next.
      pending <= (pending & ~(take ? pick_mask : 3'b000)) | wr_set;
      case (state)
        IDLE: begin
          if (take) begin
            sel   <= pick;
            bin   <= pick_val[CONV_BITS-1:0];
            bcd   <= '0;
            over  <= (pick_val > 32'd99);
            count <= CNT_W'(CONV_BITS);
          end
        end
        SHIFT: begin
          bcd   <= {hi_adj, lo_adj, bin[CONV_BITS-1]};
          bin   <= {bin[CONV_BITS-2:0], 1'b0};
          count <= count - CNT_W'(1);
        end
        STORE: begin
          case (sel)
            ADDR_PORT0: begin hex1 <= tens_seg; hex0 <= units_seg; end
            ADDR_PORT1: begin hex3 <= tens_seg; hex2 <= units_seg; end
            ADDR_PORT2: begin hex5 <= tens_seg; hex4 <= units_seg; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE) || (pending != '0);

endmodule
